// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// the 34-bit core instruction word layout and the idle instruction word.
package core_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        W_RD,
        W_LOAD,
        X_RD,
        EXEC,
        DRAIN,
        DONE
    } seqState_t;

    // Instruction word, MSB first:
    // [33] acc, [32] psum CEN, [31] psum WEN, [30:20] psum addr,
    // [19] xMem CEN, [18] xMem WEN, [17:7] xMem addr, [6] ofifo_rd,
    // [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
    typedef struct packed {
        logic              acc;
        logic              psumCen;
        logic              psumWen;
        logic [ADDR_W-1:0] psumAddr;
        logic              xCen;
        logic              xWen;
        logic [ADDR_W-1:0] xAddr;
        logic              ofifoRd;
        logic              ififoWr;
        logic              ififoRd;
        logic              l0Rd;
        logic              l0Wr;
        logic              execute;
        logic              load;
    } instWord_t;

    // Both SRAMs disabled, no strobes, addresses zero; xMem addr bit 0
    // always carries the latched dataflow mode.
    function automatic instWord_t idleInst(input logic latchedMode);
        instWord_t w;
        w          = '0;
        w.psumCen  = 1'b1;
        w.psumWen  = 1'b1;
        w.xCen     = 1'b1;
        w.xWen     = 1'b1;
        w.xAddr[0] = latchedMode;
        return w;
    endfunction

    // Vector address: base with bit 0 cleared, stepped by two per vector,
    // with the mode bit placed in bit 0.
    function automatic logic [ADDR_W-1:0] vecAddr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-2:0] idx,
                                                  input logic              m);
        logic [ADDR_W-1:0] even;
        even = (base & ~ADDR_W'(1)) + {idx, 1'b0};
        return even | {{(ADDR_W-1){1'b0}}, m};
    endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// Host-side bundle of the sequencer: pass launch fields, output-FIFO
// valid, and the generated instruction word with status.
interface core_inst_seq_if;
    import core_pkg::*;

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] n_vec;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] p_base;
    logic              valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, n_vec, w_base, x_base, p_base, valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, mode, n_vec, w_base, x_base, p_base, valid,
        output inst, busy, done
    );

endinterface

// File: rtl/sram_lat_pipe.sv
// One-stage delay of strobes and an address, used to line up L0 writes
// and psum writes with the one-cycle SRAM read latency.
module sram_lat_pipe #(
    parameter int SW = 1,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] strobeIn,
    input  logic [AW-1:0] addrIn,
    output logic [SW-1:0] strobeOut,
    output logic [AW-1:0] addrOut
);

    // Register strobes and address; reset clears any in-flight strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobeOut <= '0;
            addrOut   <= '0;
        end else begin
            strobeOut <= strobeIn;
            addrOut   <= addrIn;
        end
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for the systolic core: walks weight load,
// activation load, execute and psum drain for one pass in either
// weight-stationary (mode 0) or output-stationary (mode 1) dataflow.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int num = 2048
) (
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.slave bus
);

    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(num - 1);
    localparam logic [CNT_W-1:0]  ROW_LAST  = CNT_W'(row - 1);
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(row + col - 2);
    localparam logic [CNT_W-1:0]  SKEW_M2   = CNT_W'(col - 2);

    seqState_t         state;
    seqState_t         stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic [CNT_W-1:0]  nVecExt;

    logic              modeQ;
    logic [ADDR_W-1:0] nVecQ;
    logic [ADDR_W-1:0] wBaseQ;
    logic [ADDR_W-1:0] xBaseQ;
    logic [ADDR_W-1:0] pBaseQ;
    logic              latchNow;

    logic              l0WrReq;
    logic              psumWrReq;
    logic [ADDR_W-1:0] psumWrAddr;
    logic              l0WrDly;
    logic              psumWrDly;
    logic [ADDR_W-1:0] psumWrAddrDly;

    instWord_t         instW;

    assign nVecExt = {1'b0, nVecQ};

    sram_lat_pipe #(
        .SW(2),
        .AW(ADDR_W)
    ) latPipe (
        .clk      (clk),
        .reset    (reset),
        .strobeIn ({l0WrReq, psumWrReq}),
        .addrIn   (psumWrAddr),
        .strobeOut({l0WrDly, psumWrDly}),
        .addrOut  (psumWrAddrDly)
    );

    // State register and phase counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Capture the pass configuration when a pass is launched from idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            modeQ  <= 1'b0;
            nVecQ  <= '0;
            wBaseQ <= '0;
            xBaseQ <= '0;
            pBaseQ <= '0;
        end else if (latchNow) begin
            modeQ  <= bus.mode;
            nVecQ  <= bus.n_vec;
            wBaseQ <= bus.w_base;
            xBaseQ <= bus.x_base;
            pBaseQ <= bus.p_base;
        end
    end

    // Next-state, counter and instruction-word decode.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt + CNT_W'(1);
        latchNow   = 1'b0;
        l0WrReq    = 1'b0;
        psumWrReq  = 1'b0;
        psumWrAddr = '0;
        instW      = idleInst(modeQ);

        case (state)
            IDLE: begin
                cntNext = '0;
                if (bus.start) begin
                    latchNow = 1'b1;
                    if (!bus.mode) begin
                        stateNext = W_RD;
                    end else if (bus.n_vec == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = X_RD;
                    end
                end
            end
            W_RD: begin
                instW.xCen  = 1'b0;
                instW.xAddr = vecAddr(wBaseQ, cnt[ADDR_W-2:0], modeQ) & ADDR_MASK;
                l0WrReq     = 1'b1;
                if (cnt == ROW_LAST) begin
                    stateNext = W_LOAD;
                    cntNext   = '0;
                end
            end
            W_LOAD: begin
                instW.load = 1'b1;
                instW.l0Rd = 1'b1;
                if (cnt == LOAD_LAST) begin
                    cntNext   = '0;
                    stateNext = (nVecQ == '0) ? DONE : X_RD;
                end
            end
            X_RD: begin
                instW.xCen  = 1'b0;
                instW.xAddr = vecAddr(xBaseQ, cnt[ADDR_W-2:0], modeQ) & ADDR_MASK;
                l0WrReq     = 1'b1;
                if (cnt == nVecExt - CNT_W'(1)) begin
                    stateNext = EXEC;
                    cntNext   = '0;
                end
            end
            EXEC: begin
                instW.execute = 1'b1;
                instW.l0Rd    = 1'b1;
                instW.acc     = modeQ;
                if (modeQ && (cnt < nVecExt)) begin
                    instW.psumCen  = 1'b0;
                    instW.psumAddr = (pBaseQ + cnt[ADDR_W-1:0]) & ADDR_MASK;
                end
                if (cnt == nVecExt + SKEW_M2) begin
                    stateNext = DRAIN;
                    cntNext   = '0;
                end
            end
            DRAIN: begin
                cntNext = cnt;
                if (cnt < nVecExt) begin
                    if (bus.valid) begin
                        instW.ofifoRd = 1'b1;
                        psumWrReq     = 1'b1;
                        psumWrAddr    = (pBaseQ + cnt[ADDR_W-1:0]) & ADDR_MASK;
                        cntNext       = cnt + CNT_W'(1);
                    end
                end else begin
                    stateNext = DONE;
                    cntNext   = '0;
                end
            end
            DONE: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
            default: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
        endcase

        if (l0WrDly) begin
            instW.l0Wr = 1'b1;
        end
        if (psumWrDly) begin
            instW.psumCen  = 1'b0;
            instW.psumWen  = 1'b0;
            instW.psumAddr = psumWrAddrDly;
        end
    end

    assign bus.inst = instW;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: one pass per scenario, with a per-cycle
// recorder of instruction-word events checked against hand-derived values.
module tb_core_inst_seq;

    logic clk;
    logic reset;

    core_inst_seq_if bus ();

    core_inst_seq #(
        .row(8),
        .col(8),
        .num(2048)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc;
    int          pulseCyc;
    int          validOrigin;
    logic [31:0] validMask;
    logic        expMode;

    logic [10:0] xRdQ[$];
    logic [10:0] psRdQ[$];
    logic [10:0] psWrQ[$];
    int          l0WrQ[$];
    int          ofifoQ[$];
    int          loadCnt, execCnt, accCnt, doneCnt, doneCyc, bit7Bad, badOfifo, strayCnt;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic validFor(input int c);
        if (c >= validOrigin && c < validOrigin + 32) return validMask[c - validOrigin];
        return 1'b1;
    endfunction

    task automatic driveNext();
        if (cyc + 1 == pulseCyc) begin
            bus.start = 1'b1;
            bus.mode  = ~expMode;
            bus.n_vec = 11'd5;
        end else begin
            bus.start = 1'b0;
        end
        bus.valid = validFor(cyc + 1);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.inst[19] === 1'b0 && bus.inst[18] === 1'b1) xRdQ.push_back(bus.inst[17:7]);
        if (bus.inst[2] === 1'b1) l0WrQ.push_back(cyc);
        if (bus.inst[0] === 1'b1) loadCnt++;
        if (bus.inst[1] === 1'b1) begin
            execCnt++;
            if (bus.inst[33] === 1'b1) accCnt++;
        end
        if (bus.inst[32] === 1'b0 && bus.inst[31] === 1'b1) psRdQ.push_back(bus.inst[30:20]);
        if (bus.inst[32] === 1'b0 && bus.inst[31] === 1'b0) psWrQ.push_back(bus.inst[30:20]);
        if (bus.inst[6] === 1'b1) begin
            ofifoQ.push_back(cyc);
            if (bus.valid !== 1'b1) badOfifo++;
        end
        if (bus.inst[5] !== 1'b0 || bus.inst[4] !== 1'b0) strayCnt++;
        if (bus.busy === 1'b1 && bus.inst[7] !== expMode) bit7Bad++;
        if (bus.done === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
        end
        driveNext();
    endtask

    task automatic applyStimulus(input logic m, input int nv, input int wb, input int xb,
                                 input int pb, input int maxCycles, input bit untilDone);
        xRdQ.delete(); psRdQ.delete(); psWrQ.delete(); l0WrQ.delete(); ofifoQ.delete();
        loadCnt = 0; execCnt = 0; accCnt = 0; doneCnt = 0; doneCyc = -1;
        bit7Bad = 0; badOfifo = 0; strayCnt = 0;
        expMode    = m;
        bus.mode   = m;
        bus.n_vec  = 11'(nv);
        bus.w_base = 11'(wb);
        bus.x_base = 11'(xb);
        bus.p_base = 11'(pb);
        cyc        = 0;
        bus.start  = 1'b1;
        bus.valid  = validFor(0);
        if (untilDone) begin
            for (int i = 0; i < maxCycles && doneCnt == 0; i++) tick();
            tick();
        end else begin
            for (int i = 0; i < maxCycles; i++) tick();
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.mode    = 1'b1;
        bus.n_vec   = 11'd3;
        bus.w_base  = '0;
        bus.x_base  = '0;
        bus.p_base  = '0;
        bus.valid   = 1'b0;
        pulseCyc    = -1;
        validOrigin = 1000;
        validMask   = '1;
        expMode     = 1'b0;
        cyc         = 0;

        // Reset held low with start asserted: start must be ignored.
        repeat (3) @(negedge clk);
        checkOutput("reset_inst", bus.inst, 34'h1_800C_0000);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", bus.busy, 0);

        // WS pass: row 8, n_vec 4, w_base 0, x_base 16, p_base 40.
        applyStimulus(1'b0, 4, 0, 16, 40, 200, 1'b1);
        checkOutput("ws_xrd_count", xRdQ.size(), 12);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("ws_wrd_addr%0d", i), xRdQ[i], 2 * i);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("ws_xrd_addr%0d", i), xRdQ[8 + i], 16 + 2 * i);
        checkOutput("ws_l0wr_count", l0WrQ.size(), 12);
        checkOutput("ws_l0wr_first", l0WrQ[0], 2);
        checkOutput("ws_l0wr_wlast", l0WrQ[7], 9);
        checkOutput("ws_l0wr_xfirst", l0WrQ[8], 25);
        checkOutput("ws_l0wr_xlast", l0WrQ[11], 28);
        checkOutput("ws_load_cycles", loadCnt, 15);
        checkOutput("ws_exec_cycles", execCnt, 11);
        checkOutput("ws_acc_cycles", accCnt, 0);
        checkOutput("ws_psum_reads", psRdQ.size(), 0);
        checkOutput("ws_psum_writes", psWrQ.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("ws_psum_wr%0d", i), psWrQ[i], 40 + i);
        checkOutput("ws_ofifo_count", ofifoQ.size(), 4);
        checkOutput("ws_ofifo_first", ofifoQ[0], 39);
        checkOutput("ws_done_count", doneCnt, 1);
        checkOutput("ws_done_cycle", doneCyc, 44);
        checkOutput("ws_bit7", bit7Bad, 0);
        checkOutput("ws_stray_fifo", strayCnt, 0);
        checkOutput("ws_idle_inst", bus.inst, 34'h1_800C_0000);
        checkOutput("ws_idle_busy", bus.busy, 0);

        // OS pass, n_vec 3, valid 1,0,0,1,1 in DRAIN, start pulse mid-pass.
        validOrigin = 14;
        validMask   = 32'hFFFF_FFF9;
        pulseCyc    = 5;
        applyStimulus(1'b1, 3, 0, 200, 100, 200, 1'b1);
        checkOutput("os_xrd_count", xRdQ.size(), 3);
        checkOutput("os_xrd_addr0", xRdQ[0], 201);
        checkOutput("os_xrd_addr2", xRdQ[2], 205);
        checkOutput("os_l0wr_count", l0WrQ.size(), 3);
        checkOutput("os_l0wr_first", l0WrQ[0], 2);
        checkOutput("os_load_cycles", loadCnt, 0);
        checkOutput("os_exec_cycles", execCnt, 10);
        checkOutput("os_acc_cycles", accCnt, 10);
        checkOutput("os_psum_reads", psRdQ.size(), 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("os_psum_rd%0d", i), psRdQ[i], 100 + i);
        checkOutput("os_psum_writes", psWrQ.size(), 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("os_psum_wr%0d", i), psWrQ[i], 100 + i);
        checkOutput("os_ofifo_count", ofifoQ.size(), 3);
        checkOutput("os_ofifo_c0", ofifoQ[0], 14);
        checkOutput("os_ofifo_c1", ofifoQ[1], 17);
        checkOutput("os_ofifo_c2", ofifoQ[2], 18);
        checkOutput("os_ofifo_novalid", badOfifo, 0);
        checkOutput("os_done_count", doneCnt, 1);
        checkOutput("os_done_cycle", doneCyc, 20);
        checkOutput("os_bit7", bit7Bad, 0);
        checkOutput("os_idle_inst", bus.inst, 34'h1_800C_0080);
        checkOutput("os_idle_busy", bus.busy, 0);
        validOrigin = 1000;
        validMask   = '1;
        pulseCyc    = -1;

        // Address wrap: x_base 2046, p_base 2047, n_vec 2.
        applyStimulus(1'b1, 2, 0, 2046, 2047, 200, 1'b1);
        checkOutput("wrap_xrd0", xRdQ[0], 2047);
        checkOutput("wrap_xrd1", xRdQ[1], 1);
        checkOutput("wrap_psum_rd0", psRdQ[0], 2047);
        checkOutput("wrap_psum_rd1", psRdQ[1], 0);
        checkOutput("wrap_psum_writes", psWrQ.size(), 2);
        checkOutput("wrap_psum_wr0", psWrQ[0], 2047);
        checkOutput("wrap_psum_wr1", psWrQ[1], 0);
        checkOutput("wrap_done_cycle", doneCyc, 15);

        // OS with n_vec 0: done one cycle after start, no SRAM access.
        applyStimulus(1'b1, 0, 0, 0, 0, 20, 1'b1);
        checkOutput("os0_done_cycle", doneCyc, 1);
        checkOutput("os0_xrd", xRdQ.size(), 0);
        checkOutput("os0_psum_rd", psRdQ.size(), 0);
        checkOutput("os0_psum_wr", psWrQ.size(), 0);
        checkOutput("os0_exec", execCnt, 0);

        // WS with n_vec 0: weights loaded, then straight to done.
        applyStimulus(1'b0, 0, 0, 0, 0, 100, 1'b1);
        checkOutput("ws0_done_cycle", doneCyc, 24);
        checkOutput("ws0_load", loadCnt, 15);
        checkOutput("ws0_xrd", xRdQ.size(), 8);
        checkOutput("ws0_exec", execCnt, 0);
        checkOutput("ws0_ofifo", ofifoQ.size(), 0);

        // Reset during EXEC of an OS pass, with start asserted alongside.
        applyStimulus(1'b1, 3, 0, 200, 100, 6, 1'b0);
        checkOutput("rst_pre_exec", bus.inst[1], 1);
        reset     = 1'b0;
        bus.start = 1'b1;
        tick();
        checkOutput("rst_inst", bus.inst, 34'h1_800C_0000);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_no_restart", bus.busy, 0);
        checkOutput("rst_no_done", doneCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/core_inst_seq.md
CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 SHALL have parameter row, default 8: number of kernel vectors loaded per WS pass.
REQ-002 SHALL have parameter col, default 8: number of PE columns; sets load/drain skew length.
REQ-003 SHALL have parameter num, default 2048: SRAM depth; addresses wrap modulo num (11-bit).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; launches a pass when idle.
REQ-007 SHALL have port mode  input  1  0 = weight stationary (WS), 1 = output stationary (OS); sampled at start.
REQ-008 SHALL have port n_vec  input  11  number of activation vectors per pass; sampled at start.
REQ-009 SHALL have ports w_base, x_base, p_base  input  11 each  xMem weight, xMem activation, psumMem base addresses; sampled at start.
REQ-010 SHALL have port valid  input  1  core output-FIFO data available.
REQ-011 SHALL have port inst  output  34  core instruction word.
REQ-012 SHALL have ports busy, done  output  1 each  pass in progress; one-cycle pass-complete pulse.

Function
REQ-013 inst field map SHALL be: [33] acc, [32] psum CEN, [31] psum WEN, [30:20] psum addr, [19] xMem CEN, [18] xMem WEN, [17:7] xMem addr, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-014 Bit 7, which carries mode, SHALL be forced to the latched mode in every cycle of a pass; generated xMem addresses are {addr[10:1], mode}; counters advance addr[10:1] by 1 per vector.
REQ-015 Idle inst SHALL be: CENs = 1, WENs = 1, all strobes = 0, addresses = 0, bit 7 = latched mode.
REQ-016 FSM states SHALL be IDLE, W_RD, W_LOAD, X_RD, EXEC, DRAIN, DONE.
REQ-017 IDLE->W_RD on start with mode = 0; IDLE->X_RD on start with mode = 1; start SHALL be ignored when busy = 1.
REQ-018 W_RD: for row cycles, xMem CEN = 0, WEN = 1, addr = w_base + i; l0_wr SHALL assert exactly 1 cycle after each read (1-cycle SRAM latency).
REQ-019 W_LOAD: load = 1 and l0_rd = 1 for row + col - 1 cycles, then X_RD.
REQ-020 X_RD: n_vec reads from x_base + i, with l0_wr delayed 1 cycle as in REQ-018, then EXEC.
REQ-021 EXEC: execute = 1 and l0_rd = 1 for n_vec + col - 1 cycles; acc SHALL equal latched mode.
REQ-022 DRAIN: each cycle valid = 1 SHALL assert ofifo_rd = 1; one cycle later, psum CEN = 0, WEN = 0, addr = p_base + k. After n_vec writes, go to DONE. valid = 0 stalls indefinitely with no strobes.
REQ-023 In OS mode, psum CEN = 0 with WEN = 1 SHALL accompany each EXEC cycle k < n_vec, at addr p_base + k (accumulate read).
REQ-024 DONE: done = 1 for one cycle, then IDLE; busy = 1 in every state except IDLE.
REQ-025 n_vec = 0 SHALL skip X_RD, EXEC and DRAIN: WS goes W_LOAD->DONE; OS goes start->DONE next cycle.
REQ-026 Address sums SHALL wrap modulo 2048 (2047 + 1 = 0) without error.

Reset
REQ-027 reset = 0 at a clock edge SHALL force IDLE, zero all counters and latched fields, and give inst = idle word with bit 7 = 0, busy = 0, done = 0, including mid-pass.
REQ-028 start SHALL be ignored in a cycle where reset = 0.

Structure
REQ-029 inst bit positions, state encoding and the idle word SHALL live in a shared package (core_pkg) used by core and sequencer.
REQ-030 The 1-cycle SRAM-latency delay of l0_wr and psum write SHALL be a sub-module, sram_lat_pipe (1-stage strobe+address delay).

Verification
REQ-031 WS, row = 8, n_vec = 4, w_base = 0, x_base = 16 -> 8 reads at even addresses 0..14, l0_wr in cycles 2..9, load asserted 15 cycles, 4 X reads, 11 execute cycles, done pulse.
REQ-032 OS, n_vec = 3, p_base = 100 -> bit 7 = 1 throughout, no load cycles, acc = 1, psum reads at 100..102, writes at 100..102.
REQ-033 DRAIN with valid toggling 1,0,0,1,1 and n_vec = 3 -> ofifo_rd exactly on valid-high cycles, 3 writes, then done.
REQ-034 p_base = 2047, n_vec = 2 -> psum write addresses 2047, 0.
REQ-035 reset = 0 during EXEC -> next cycle inst = idle word, busy = 0; start during busy is ignored (no restart).
REQ-036 n_vec = 0 in OS mode -> done one cycle after start, no SRAM access.
